// File: rtl/stream_uart_pkg.sv
// rtl/stream_uart_pkg.sv - shared types and framing constants for the stream UART transmitter
package stream_uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO; a push into a full FIFO is taken when a pop happens the same cycle
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_pop   = pop && !empty;
        // the slot being read this cycle is free for the incoming write
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/stream_uart_tx.sv
// rtl/stream_uart_tx.sv - absorbs a no-backpressure byte stream into a FIFO and serialises it 8N1 on tx
// Optional even parity bit after the data bits when STREAM_UART_TX_PARITY_EN is defined.
module stream_uart_tx
    import stream_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          s_axis_tvalid,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          clear_overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 overflow_q, overflow_d;
`ifdef STREAM_UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 pop, full, empty, bit_done, drop;
    logic [7:0]           pop_data;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (s_axis_tvalid),
        .push_data (s_axis_tdata),
        .pop       (pop),
        .pop_data  (pop_data),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) || !empty;
    assign bit_done = (timer_q == TIMER_LAST);
    assign drop     = s_axis_tvalid && full && !pop;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        pop       = 1'b0;
`ifdef STREAM_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != ST_IDLE) begin
            timer_d = bit_done ? '0 : timer_q + TW'(1);
        end
        // tx is driven from the current state, so the pin lags the FSM by one cycle
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = pop_data;
`ifdef STREAM_UART_TX_PARITY_EN
                    parity_d  = ^pop_data;
`endif
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
`ifdef STREAM_UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef STREAM_UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = parity_q;
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // a drop in the same cycle wins over a clear request
        overflow_d = drop || (overflow_q && !clear_overflow);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef STREAM_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef STREAM_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule
